axi_lite_mem_slave: RTL
=======================

# axi_lite_mem_slave

AXI4-Lite slave memory that terminates the `mem_axi_*` master port of `picorv32_axi`, sitting directly downstream of the core in simulation and formal benches. It accepts one read or write transaction at a time, applies byte-strobed writes to an internal word array, and returns read data after a programmable number of wait states. It never reorders transactions, never issues unsolicited responses, and keeps every response channel stable until accepted.

## Interface

Parameters:
- `MEM_WORDS`, 256, number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 0, extra wait cycles between address/data acceptance and `bvalid`/`rvalid`; legal range 0..12.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_axi_awvalid`  in  1  write address valid.
- `mem_axi_awready`  out  1  write address accepted.
- `mem_axi_awaddr`  in  32  byte address.
- `mem_axi_awprot`  in  3  ignored.
- `mem_axi_wvalid`  in  1  write data valid.
- `mem_axi_wready`  out  1  write data accepted.
- `mem_axi_wdata`  in  32  write data.
- `mem_axi_wstrb`  in  4  byte enables; bit n covers `wdata[8n+7:8n]`.
- `mem_axi_bvalid`  out  1  write response valid.
- `mem_axi_bready`  in  1  write response accepted.
- `mem_axi_arvalid`  in  1  read address valid.
- `mem_axi_arready`  out  1  read address accepted.
- `mem_axi_araddr`  in  32  byte address.
- `mem_axi_arprot`  in  3  ignored.
- `mem_axi_rvalid`  out  1  read data valid.
- `mem_axi_rready`  in  1  read data accepted.
- `mem_axi_rdata`  out  32  read data.

## Operation

- Word index = `addr[log2(MEM_WORDS)+1:2]`. Bits [1:0] and all upper bits are ignored, so addresses wrap modulo `4*MEM_WORDS`.
- All ready and valid outputs are registered. No combinational path runs from any input to any output.
- FSM states: IDLE, WACC, RACC, WDLY, RDLY, BRESP, RRESP.
- IDLE: all readies 0, `bvalid`=`rvalid`=0.
  - `awvalid && wvalid` → WACC.
  - Else `arvalid` → RACC.
  - Write wins when both requests are present.
  - `awvalid` without `wvalid` (or the reverse) waits in IDLE.
- WACC (one cycle): `awready`=`wready`=1. Both handshakes complete this cycle; the master holds its valids, per AXI.
  - Latch the index. For each n with `wstrb[n]`=1, write byte n of the word.
  - Next state: WDLY if `LATENCY`>0, else BRESP.
- RACC (one cycle): `arready`=1.
  - Register `rdata` from the word at the araddr index, reflecting all previously completed writes.
  - Next state: RDLY if `LATENCY`>0, else RRESP.
- WDLY / RDLY: count `LATENCY` cycles with all outputs idle, then go to BRESP / RRESP.
- BRESP: `bvalid`=1 until a cycle with `bready`=1, then IDLE (`bvalid`=0 next cycle).
- RRESP: `rvalid`=1 and `rdata` held stable until a cycle with `rready`=1, then IDLE.
- At most one transaction is in flight. No address channel is accepted while any response is pending.
- `wstrb`=0 performs the handshake and response without modifying memory.
- Memory contents are not reset and are undefined until written.

## Timing

- Reset: next edge forces IDLE and drives `awready`=`wready`=`arready`=`bvalid`=`rvalid`=0 and `rdata`=0. This applies mid-transaction too: pending responses are dropped and already-written memory is retained.
- Write with both valids first high at cycle T:
  - `awready`/`wready` high at T+1.
  - Memory updated at the T+1 edge.
  - `bvalid` high at T+2+`LATENCY`.
- Read with `arvalid` first high at T (no write request):
  - `arready` high at T+1.
  - `rvalid`/`rdata` at T+2+`LATENCY`.
- Response accepted at cycle R → back-to-back request sampled at R+1 is accepted at R+2. Minimum transaction period is 3+`LATENCY` cycles.
- Every valid→ready wait is ≤ 1 cycle. Worst response delay from address acceptance is `LATENCY`+1 ≤ 13 cycles, inside the 15-cycle stall bound the core's formal checks use.
- A read sees a prior write once that write's `bvalid` has been issued.

## Test plan

- Reset then idle, `LATENCY`=0:
  - hold `reset` 2 cycles → all outputs 0.
  - read 0x0 after writing 0x12345678 → `rdata`=0x12345678 at T+2.
- Byte strobes:
  - write 0xFFFFFFFF to 0x10, then write 0xAABBCCDD with `wstrb`=4'b0101.
  - read 0x10 → 0xFFBBFFDD.
  - `wstrb`=0 → word unchanged, `bvalid` still issued.
- Backpressure, `LATENCY`=3:
  - hold `rready`=0 for 5 cycles after `rvalid` → `rvalid`=1 and `rdata` constant throughout.
  - `rvalid` first at T+5; same pattern applies on `bready`.
- Simultaneous requests and wrap:
  - `awvalid`+`wvalid`+`arvalid` in the same cycle → write accepted first; read accepted only after the B handshake.
  - with `MEM_WORDS`=256, write to 0x400 → read of 0x000 returns that data.
- Reset mid-operation:
  - assert `reset` while in RRESP with `rvalid`=1 → `rvalid`=0 next cycle, FSM in IDLE.
  - a subsequent read returns the data written before the reset.
- Protocol soak: connect to `picorv32_axi` running a load/store program with `LATENCY` swept 0..12 → correct architectural results; no valid dropped without a handshake; no trap.

Source files
------------

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between a single master and the memory slave.
// Every channel transfers on a rising edge where its valid and ready are both 1;
// a raised valid and its payload stay unchanged until that transfer happens.
interface axi_lite_mem_slave_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// Single-outstanding AXI4-Lite word memory with byte strobes and a fixed
// number of wait states before each response; all bus outputs are flops.
module axi_lite_mem_slave #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  axi_lite_mem_slave_if.slave        mem_axi,
  output logic [2:0]                 state_dbg
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] DLY_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WACC  = 3'd1,
    RACC  = 3'd2,
    WDLY  = 3'd3,
    RDLY  = 3'd4,
    BRESP = 3'd5,
    RRESP = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    dly_cnt, dly_cnt_nx;
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] widx, ridx;
  logic          unused_bits;

  // Upper address bits are dropped so the array aliases modulo 4*MEM_WORDS.
  assign widx = mem_axi.awaddr[AW+1:2];
  assign ridx = mem_axi.araddr[AW+1:2];
  assign unused_bits = ^{mem_axi.awprot, mem_axi.arprot,
                         mem_axi.awaddr[31:AW+2], mem_axi.awaddr[1:0],
                         mem_axi.araddr[31:AW+2], mem_axi.araddr[1:0]};
  assign state_dbg = state;

  always_comb begin
    state_nx   = state;
    dly_cnt_nx = dly_cnt;
    case (state)
      IDLE: begin
        if (mem_axi.awvalid && mem_axi.wvalid) state_nx = WACC;
        else if (mem_axi.arvalid)              state_nx = RACC;
      end
      WACC: begin
        if (LATENCY > 0) begin
          state_nx   = WDLY;
          dly_cnt_nx = DLY_LOAD;
        end else begin
          state_nx = BRESP;
        end
      end
      RACC: begin
        if (LATENCY > 0) begin
          state_nx   = RDLY;
          dly_cnt_nx = DLY_LOAD;
        end else begin
          state_nx = RRESP;
        end
      end
      WDLY: begin
        if (dly_cnt == 4'd0) state_nx = BRESP;
        else                 dly_cnt_nx = dly_cnt - 4'd1;
      end
      RDLY: begin
        if (dly_cnt == 4'd0) state_nx = RRESP;
        else                 dly_cnt_nx = dly_cnt - 4'd1;
      end
      BRESP: if (mem_axi.bready) state_nx = IDLE;
      RRESP: if (mem_axi.rready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      dly_cnt         <= 4'd0;
      mem_axi.awready <= 1'b0;
      mem_axi.wready  <= 1'b0;
      mem_axi.arready <= 1'b0;
      mem_axi.bvalid  <= 1'b0;
      mem_axi.rvalid  <= 1'b0;
      mem_axi.rdata   <= 32'd0;
    end else begin
      state           <= state_nx;
      dly_cnt         <= dly_cnt_nx;
      mem_axi.awready <= (state_nx == WACC);
      mem_axi.wready  <= (state_nx == WACC);
      mem_axi.arready <= (state_nx == RACC);
      mem_axi.bvalid  <= (state_nx == BRESP);
      mem_axi.rvalid  <= (state_nx == RRESP);
      if (state == RACC) mem_axi.rdata <= mem[ridx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == WACC) begin
      for (int n = 0; n < 4; n++) begin
        if (mem_axi.wstrb[n]) mem[widx][8*n +: 8] <= mem_axi.wdata[8*n +: 8];
      end
    end
  end

endmodule
